// File: rtl/dm_pkg.sv
// Shared types and constants for the dcache <-> data memory line interface.
package dm_pkg;

   localparam int DM_LINE_W   = 256;
   localparam int DM_OFFSET_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dm_state_e;

   typedef logic [DM_LINE_W-1:0] dm_line_t;

endpackage

// File: rtl/dm_line_array.sv
// Single-port DEPTH x LINE_W line store: synchronous write, registered read of idx every cycle.
module dm_line_array #(
   parameter int LINE_W = 256,
   parameter int DEPTH  = 512,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] mem [DEPTH];

   // Read-first: rdata shows the old line on a write edge; the responder never relies on that case.
   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/dm_line_responder.sv
// Memory-side line responder: one request at a time, fixed latency, single-cycle registered ack.
module dm_line_responder
   import dm_pkg::*;
#(
   parameter int LINE_W  = DM_LINE_W,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   dm_state_e         state;
   logic [7:0]        cnt;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] data_q;
   logic              wr_q;

   logic [IDX_W-1:0]  idx_in;
   logic [IDX_W-1:0]  arr_idx;
   logic              arr_we;
   logic [LINE_W-1:0] arr_rdata;
   logic              unused_addr_bits;

   // DEPTH is a power of two, so the modulo wrap is just a bit slice of the line number.
   assign idx_in           = addr_i[DM_OFFSET_W +: IDX_W];
   assign unused_addr_bits = ^{addr_i[DM_OFFSET_W-1:0], addr_i[ADDR_W-1:DM_OFFSET_W+IDX_W]};

   // In IDLE the array is addressed straight from the port so a LATENCY=1 read has its line ready.
   assign arr_idx = (state == IDLE) ? idx_in : idx_q;
   assign arr_we  = (state == BUSY) && (cnt == 8'd0) && wr_q;

   dm_line_array #(
      .LINE_W (LINE_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i  (clk_i),
      .we     (arr_we),
      .idx    (arr_idx),
      .wdata  (data_q),
      .rdata  (arr_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         ack_o  <= 1'b0;
         data_o <= '0;
         idx_q  <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
      end else begin
         ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (enable_i) begin
                  idx_q  <= idx_in;
                  data_q <= data_i;
                  wr_q   <= write_i;
                  cnt    <= CNT_INIT;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  state <= DONE;
                  ack_o <= 1'b1;
                  if (!wr_q) begin
                     data_o <= arr_rdata;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_line_responder.sv
// Directed bench for dm_line_responder: a LATENCY=10 instance and a LATENCY=1 instance.
module tb_dm_line_responder;
   import dm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   dm_line_t    wdata = '0;
   logic        wr = 1'b0;
   logic        en_a = 1'b0;
   logic        en_b = 1'b0;
   logic        ack_a, ack_b;
   dm_line_t    q_a, q_b;

   int passed = 0;
   int total  = 0;

   localparam dm_line_t L5   = 256'h5;
   localparam dm_line_t LDB  = {8{32'hDEADBEEF}};
   localparam dm_line_t LA5  = {32{8'hA5}};
   localparam dm_line_t L12  = 256'h1234;
   localparam dm_line_t LBAD = 256'hBAD0_BAD0;
   localparam dm_line_t LC   = {16{16'hC3C3}};
   localparam dm_line_t LJNK = {8{32'h0BADF00D}};

   always #5 clk = ~clk;

   dm_line_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(10)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
      .enable_i(en_a), .write_i(wr), .ack_o(ack_a), .data_o(q_a));

   dm_line_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(1)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(wdata),
      .enable_i(en_b), .write_i(wr), .ack_o(ack_b), .data_o(q_b));

   typedef struct {
      logic [31:0] addr;
      dm_line_t    data;
      bit          wr;
      dm_line_t    exp_q;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input dm_line_t act, input dm_line_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One request on the selected instance; returns edges from acceptance to ack and data_o at ack.
   task automatic req(input bit sel, input logic [31:0] a, input dm_line_t d, input bit w,
                      input bit hold, output int lat, output dm_line_t q);
      logic ack;
      @(negedge clk);
      addr = a; wdata = d; wr = w;
      if (sel) en_b = 1'b1; else en_a = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin en_a = 1'b0; en_b = 1'b0; end
      lat = 0;
      ack = 1'b0;
      while (!ack && lat < 50) begin
         @(posedge clk); #1;
         lat++;
         ack = sel ? ack_b : ack_a;
      end
      q = sel ? q_b : q_a;
      en_a = 1'b0; en_b = 1'b0;
      chk("ack_seen", 256'(ack), 256'd1);
      @(posedge clk); #1;
      chk("ack_one_cycle", 256'(sel ? ack_b : ack_a), 256'd0);
   endtask

   logic [31:0] b2b_addr [3];
   dm_line_t    b2b_exp [3];

   initial begin
      int lat;
      dm_line_t q;
      int idx;
      int k, t, t_prev;

      vecs[0] = '{32'h0000_0000, L5,  1'b1, 256'h0};
      vecs[1] = '{32'h0000_0000, '0,  1'b0, L5};
      vecs[2] = '{32'h0000_0400, LDB, 1'b1, L5};
      vecs[3] = '{32'h0000_041F, '0,  1'b0, LDB};
      vecs[4] = '{32'h0000_7FE0, LA5, 1'b1, LDB};
      vecs[5] = '{32'h0000_3FE0, '0,  1'b0, LA5};
      vecs[6] = '{32'h0000_0000, '0,  1'b0, L5};
      vecs[7] = '{32'h0000_0020, L12, 1'b1, L5};
      vecs[8] = '{32'h0000_0020, '0,  1'b0, L12};

      // Reset held with a write request pending on both instances.
      en_a = 1'b1; en_b = 1'b1; wr = 1'b1; wdata = '1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rst_ack", 256'(ack_a), 256'd0);
         chk("rst_data", q_a, '0);
      end
      en_a = 1'b0; en_b = 1'b0; wr = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         req(1'b0, vecs[i].addr, vecs[i].data, vecs[i].wr, 1'b1, lat, q);
         chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd10);
         chk($sformatf("vec%0d_data_o", i), q, vecs[i].exp_q);
         if (vecs[i].wr) begin
            idx = int'(vecs[i].addr >> 5) % 512;
            chk($sformatf("vec%0d_line", i), dut_a.u_array.mem[idx], vecs[i].data);
         end
      end

      // enable_i dropped right after acceptance: request still completes.
      req(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, lat, q);
      chk("early_drop_latency", 256'(lat), 256'd10);
      chk("early_drop_data", q, LDB);

      // Back-to-back reads with enable held; junk write request applied while BUSY.
      b2b_addr[0] = 32'h0000_0000; b2b_exp[0] = L5;
      b2b_addr[1] = 32'h0000_0400; b2b_exp[1] = LDB;
      b2b_addr[2] = 32'h0000_0020; b2b_exp[2] = L12;
      @(negedge clk);
      addr = b2b_addr[0]; wr = 1'b0; en_a = 1'b1;
      k = 0; t = 0; t_prev = 0;
      while (k < 3 && t < 100) begin
         @(posedge clk); #1;
         t++;
         if (ack_a) begin
            chk($sformatf("b2b%0d_data", k), q_a, b2b_exp[k]);
            if (k > 0) chk($sformatf("b2b%0d_spacing", k), 256'(t - t_prev), 256'd12);
            t_prev = t;
            k++;
            if (k < 3) begin addr = b2b_addr[k]; wr = 1'b0; wdata = '0; end
            else en_a = 1'b0;
         end else if (t == ((k == 0) ? 4 : t_prev + 4)) begin
            addr = 32'h0000_7FE0; wr = 1'b1; wdata = LJNK;
         end
      end
      en_a = 1'b0; wr = 1'b0;
      chk("b2b_count", 256'(k), 256'd3);
      chk("b2b_junk_not_written", dut_a.u_array.mem[511], LA5);
      repeat (14) begin
         @(posedge clk); #1;
         chk("b2b_no_extra_ack", 256'(ack_a), 256'd0);
      end

      // Reset during a write aborts it: no ack, line keeps old contents.
      @(negedge clk);
      addr = 32'h0000_0020; wdata = LBAD; wr = 1'b1; en_a = 1'b1;
      @(posedge clk); #1;
      en_a = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("midrst_data_cleared", q_a, '0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("midrst_no_ack", 256'(ack_a), 256'd0);
      end
      chk("midrst_line_kept", dut_a.u_array.mem[1], L12);
      req(1'b0, 32'h0000_0020, '0, 1'b0, 1'b1, lat, q);
      chk("midrst_read_latency", 256'(lat), 256'd10);
      chk("midrst_read_data", q, L12);

      // LATENCY=1 instance: address wrap of line 512 onto line 0.
      req(1'b1, 32'h0000_4000, LC, 1'b1, 1'b1, lat, q);
      chk("wrap_write_latency", 256'(lat), 256'd1);
      chk("wrap_write_data_o", q, '0);
      chk("wrap_line0", dut_b.u_array.mem[0], LC);
      req(1'b1, 32'h0000_0000, '0, 1'b0, 1'b1, lat, q);
      chk("wrap_read_latency", 256'(lat), 256'd1);
      chk("wrap_read_data", q, LC);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
